// File: rtl/tick_scheduler.sv
// Shared time base: one BASE_DIV prescaler feeding NCH programmable tick / slow-clock channels.
// Channel reconfiguration is deferred to the next base tick so channel outputs never glitch.
module tick_scheduler #(
    parameter int unsigned BASE_DIV = 2500,
    parameter int unsigned NCH      = 4,
    parameter int unsigned DW       = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [DW-1:0]          cfg_div,
    input  logic                   cfg_en,
    output logic                   busy,
    output logic                   base_tick,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         sclk
);

    localparam int unsigned CW = $clog2(NCH);
    localparam int unsigned PW = $clog2(BASE_DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(BASE_DIV - 1);

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [DW-1:0] div;
        logic          en;
    } cfg_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    cfg_t          shadow_q;
    logic          shadow_load;
    logic          apply;
    logic [PW-1:0] pcnt;
    logic [NCH-1:0] en_q;
    logic [DW-1:0] div_q  [NCH];
    logic [DW-1:0] ccnt_q [NCH];

    // Prescaler: base_tick is high the cycle after pcnt reaches its last value.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pcnt      <= '0;
            base_tick <= 1'b0;
        end else begin
            base_tick <= (pcnt == PCNT_LAST);
            pcnt      <= (pcnt == PCNT_LAST) ? '0 : pcnt + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A request waits in the shadow register until the next base tick.
    always_comb begin
        state_d     = state_q;
        cfg_ready   = 1'b0;
        busy        = 1'b0;
        shadow_load = 1'b0;
        apply       = 1'b0;
        case (state_q)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    shadow_load = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (base_tick) begin
                    apply   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shadow_q <= '0;
        end else if (shadow_load) begin
            shadow_q.ch  <= cfg_ch;
            shadow_q.div <= cfg_div;
            shadow_q.en  <= cfg_en;
        end
    end

    // Channel dividers; a pending apply overrides that channel's terminal count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            en_q <= NCH'(1);
            tick <= '0;
            sclk <= '0;
            for (int i = 0; i < NCH; i++) begin
                div_q[i]  <= '0;
                ccnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                tick[i] <= 1'b0;
                if (apply && (shadow_q.ch == CW'(i))) begin
                    div_q[i]  <= shadow_q.div;
                    en_q[i]   <= shadow_q.en;
                    ccnt_q[i] <= '0;
                    sclk[i]   <= 1'b0;
                end else if (!en_q[i]) begin
                    ccnt_q[i] <= '0;
                    sclk[i]   <= 1'b0;
                end else if (base_tick) begin
                    if (ccnt_q[i] == div_q[i]) begin
                        ccnt_q[i] <= '0;
                        tick[i]   <= 1'b1;
                        sclk[i]   <= ~sclk[i];
                    end else begin
                        ccnt_q[i] <= ccnt_q[i] + DW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: stimulus queues expected pulse cycles, a negedge
// monitor pops and compares them whenever base_tick, a tick or a config accept appears.
module tb_tick_scheduler;

    localparam int unsigned BASE_DIV = 10;
    localparam int unsigned NCH      = 4;
    localparam int unsigned DW       = 4;
    localparam int          NQ       = 6;   // 0..3 tick[i], 4 base_tick, 5 cfg accept

    logic           clk;
    logic           rstn;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic           cfg_en;
    logic           busy;
    logic           base_tick;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sclk;

    typedef struct packed {
        int   cyc;
        logic s;
    } ev_t;

    ev_t exp_q [NQ][$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    tick_scheduler #(
        .BASE_DIV(BASE_DIV),
        .NCH     (NCH),
        .DW      (DW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_en   (cfg_en),
        .busy     (busy),
        .base_tick(base_tick),
        .tick     (tick),
        .sclk     (sclk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle n is the clock period ending at the n-th edge after reset release (edge 0 first).
    always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

    function automatic string qname(input int q);
        case (q)
            4:       return "base_tick";
            5:       return "cfg_accept";
            default: return $sformatf("tick[%0d]", q);
        endcase
    endfunction

    task automatic pop_check(input int q, input logic s);
        ev_t ev;
        checks++;
        if (exp_q[q].size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event at cycle %0d", qname(q), cyc);
        end else begin
            ev = exp_q[q].pop_front();
            if (ev.cyc != cyc || (q < 4 && ev.s !== s)) begin
                errors++;
                $display("FAIL %s: got cycle %0d sclk %b, expected cycle %0d sclk %b",
                         qname(q), cyc, s, ev.cyc, ev.s);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (base_tick === 1'b1) pop_check(4, 1'b0);
            for (int i = 0; i < NCH; i++) begin
                if (tick[i] === 1'b1) pop_check(i, sclk[i]);
            end
            if (cfg_valid === 1'b1 && cfg_ready === 1'b1) pop_check(5, 1'b0);
        end
    end

    task automatic push_ev(input int q, input int c, input logic s);
        ev_t ev;
        ev.cyc = c;
        ev.s   = s;
        exp_q[q].push_back(ev);
    endtask

    task automatic push_base(input int n);
        for (int k = 1; k <= n; k++) push_ev(4, 10 * k, 1'b0);
    endtask

    // Channel 0 at reset defaults: one tick per base tick, sclk toggling from 0.
    task automatic push_ch0(input int n);
        for (int k = 1; k <= n; k++) push_ev(0, 10 * k + 1, (k % 2) == 1);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic drain_check(input string phase);
        for (int q = 0; q < NQ; q++) begin
            checks++;
            if (exp_q[q].size() != 0) begin
                errors++;
                $display("FAIL %s %s: %0d expected events never seen, next at cycle %0d",
                         phase, qname(q), exp_q[q].size(), exp_q[q][0].cyc);
                exp_q[q].delete();
            end
        end
    endtask

    task automatic go_to(input int n);
        int guard;
        guard = 0;
        while (cyc != n) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 1000) begin
                errors++;
                $display("FAIL go_to: cycle %0d never reached (at %0d)", n, cyc);
                $fatal(1, "bench stalled");
            end
        end
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_en    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic send(input logic [1:0] ch, input logic [DW-1:0] dv, input logic en);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = dv;
        cfg_en    = en;
    endtask

    initial begin
        rstn      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_en    = 1'b0;

        // Reset defaults
        do_reset();
        chk("reset base_tick", int'(base_tick), 0);
        chk("reset tick", int'(tick), 0);
        chk("reset sclk", int'(sclk), 0);
        chk("reset cfg_ready", int'(cfg_ready), 1);
        chk("reset busy", int'(busy), 0);
        push_base(3);
        push_ch0(3);
        for (int c = 1; c <= 34; c++) begin
            go_to(c);
            chk("idle cfg_ready", int'(cfg_ready), 1);
        end
        chk("defaults sclk", int'(sclk), 1);
        chk("defaults tick", int'(tick), 0);
        go_to(35);
        drain_check("reset_defaults");

        // Program channel 1: div=3, applied at cycle 10
        do_reset();
        push_base(13);
        push_ch0(13);
        push_ev(5, 2, 1'b0);
        push_ev(1, 51, 1'b1);
        push_ev(1, 91, 1'b0);
        push_ev(1, 131, 1'b1);
        go_to(2);
        chk("pre-accept busy", int'(busy), 0);
        send(2'd1, 4'd3, 1'b1);
        go_to(3);
        cfg_valid = 1'b0;
        chk("wait busy", int'(busy), 1);
        chk("wait cfg_ready", int'(cfg_ready), 0);
        go_to(10);
        chk("wait busy at apply", int'(busy), 1);
        go_to(11);
        chk("post-apply busy", int'(busy), 0);
        chk("post-apply cfg_ready", int'(cfg_ready), 1);
        go_to(135);
        drain_check("program_ch1");

        // Disable channel 0, apply colliding with its terminal count at cycle 20
        do_reset();
        push_base(4);
        push_ev(0, 11, 1'b1);
        push_ev(5, 19, 1'b0);
        go_to(15);
        chk("ch0 sclk before disable", int'(sclk[0]), 1);
        go_to(19);
        send(2'd0, 4'd0, 1'b0);
        go_to(20);
        cfg_valid = 1'b0;
        chk("one-cycle wait busy", int'(busy), 1);
        go_to(21);
        chk("collision tick[0]", int'(tick[0]), 0);
        chk("collision sclk[0]", int'(sclk[0]), 0);
        chk("collision busy", int'(busy), 0);
        go_to(44);
        chk("disabled sclk", int'(sclk), 0);
        go_to(45);
        drain_check("disable_collision");

        // Backpressure: valid held through WAIT with changing payloads
        do_reset();
        push_base(8);
        push_ch0(8);
        push_ev(5, 3, 1'b0);
        push_ev(5, 11, 1'b0);
        push_ev(2, 31, 1'b1);
        push_ev(2, 51, 1'b0);
        push_ev(2, 71, 1'b1);
        push_ev(3, 51, 1'b1);
        push_ev(3, 81, 1'b0);
        go_to(3);
        send(2'd2, 4'd1, 1'b1);
        for (int c = 4; c <= 10; c++) begin
            go_to(c);
            send(2'd1, DW'(c % 4), 1'b1);
            chk("held-valid busy", int'(busy), 1);
        end
        go_to(11);
        chk("return cfg_ready", int'(cfg_ready), 1);
        send(2'd3, 4'd2, 1'b1);
        go_to(12);
        cfg_valid = 1'b0;
        chk("second wait busy", int'(busy), 1);
        go_to(85);
        drain_check("backpressure");

        // Reset pulse while a request is pending
        do_reset();
        push_ev(5, 2, 1'b0);
        go_to(2);
        send(2'd2, 4'd1, 1'b1);
        go_to(3);
        cfg_valid = 1'b0;
        chk("pending busy", int'(busy), 1);
        go_to(7);
        drain_check("pre_reset_pulse");
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("after pulse cfg_ready", int'(cfg_ready), 1);
        chk("after pulse busy", int'(busy), 0);
        chk("after pulse tick", int'(tick), 0);
        push_base(3);
        push_ch0(3);
        go_to(35);
        chk("ch2 never enabled sclk", int'(sclk[2]), 0);
        drain_check("reset_mid_wait");

        // Maximum divisor on channel 3
        do_reset();
        push_base(33);
        push_ch0(33);
        push_ev(5, 1, 1'b0);
        push_ev(3, 171, 1'b1);
        push_ev(3, 331, 1'b0);
        go_to(1);
        send(2'd3, 4'd15, 1'b1);
        go_to(2);
        cfg_valid = 1'b0;
        go_to(335);
        drain_check("max_divisor");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
